// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 keypad column scanner and frame debouncer.
// Emits an active-low 16-bit raw key vector, bit 4*col+row.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] key_n,
  output logic        frame_done,
  output logic        key_change
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEB_MAX = SW'(DEB_FRAMES - 1);

  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [CW-1:0] cnt;
  logic [1:0]    col;
  logic [15:0]   frame;
  logic [15:0]   prev;
  logic [SW-1:0] stable;
  logic [15:0]   frame_nxt;
  logic [SW-1:0] stable_nxt;
  logic          samp;
  logic          last;

  assign samp = (cnt == DIV_MAX);
  assign last = samp && (col == 2'd3);

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_n;
      row_s <= row_m;
    end
  end

  // Dwell counter and column drive; the column rotates on each sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      col   <= 2'd0;
      col_n <= 4'b1110;
    end else if (samp) begin
      cnt   <= '0;
      col   <= col + 2'd1;
      col_n <= {col_n[2:0], col_n[3]};
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // Frame with the current nibble merged in, and the next debounce count.
  always_comb begin
    frame_nxt = frame;
    frame_nxt[{col, 2'b00} +: 4] = row_s;
    stable_nxt = stable;
    if (frame_nxt != prev) begin
      stable_nxt = '0;
    end else if (stable < DEB_MAX) begin
      stable_nxt = stable + SW'(1);
    end
  end

  // Frame assembly: capture the synchronized rows at each sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= 16'hFFFF;
    end else if (samp) begin
      frame <= frame_nxt;
    end
  end

  // Whole-frame debounce; key_n moves only after enough identical frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= 16'hFFFF;
      stable     <= '0;
      key_n      <= 16'hFFFF;
      frame_done <= 1'b0;
      key_change <= 1'b0;
    end else begin
      frame_done <= last;
      key_change <= 1'b0;
      if (last) begin
        prev   <= frame_nxt;
        stable <= stable_nxt;
        if (stable_nxt == DEB_MAX && frame_nxt != key_n) begin
          key_n      <= frame_nxt;
          key_change <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed bench for the keypad scanner.
// A behavioural keypad drives row_n from col_n and a pressed-key mask.
module tb_keypad_matrix_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] key_n;
  logic        frame_done;
  logic        key_change;

  logic [15:0] press;
  int          total;
  int          bad;
  int          kc_cnt;
  int          kc0;

  keypad_matrix_scanner #(
    .SCAN_DIV   (4),
    .DEB_FRAMES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_n      (key_n),
    .frame_done (frame_done),
    .key_change (key_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_n[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (press[4*c+r]) row_n[r] = 1'b0;
        end
      end
    end
  end

  // Count key_change pulses.
  always @(negedge clk) begin
    if (key_change) kc_cnt <= kc_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_frame;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    if (!frame_done) chk("frame_timeout", {31'd0, frame_done}, 32'd1);
  endtask

  // Wait n frames, checking key_n (and that no pulse occurs) at each.
  task automatic hold_frames(input string tag, input int n,
                             input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      wait_frame();
      chk(tag, {16'd0, key_n}, {16'd0, exp});
      chk({tag, "_kc"}, {31'd0, key_change}, 32'd0);
    end
  endtask

  task automatic accept(input string tag, input logic [15:0] exp);
    wait_frame();
    chk(tag, {16'd0, key_n}, {16'd0, exp});
    chk({tag, "_kc"}, {31'd0, key_change}, 32'd1);
  endtask

  initial begin
    logic [3:0] ec;
    total  = 0;
    bad    = 0;
    kc_cnt = 0;
    press  = 16'h0000;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", {28'd0, col_n}, 32'hE);
    chk("rst_key", {16'd0, key_n}, 32'hFFFF);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_kc", {31'd0, key_change}, 32'd0);
    rst_n = 1'b1;

    // Idle sweeps: column order, dwell and frame_done cadence.
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      ec = 4'hF;
      ec[(k/4)%4] = 1'b0;
      chk("idle_col", {28'd0, col_n}, {28'd0, ec});
      chk("idle_fd", {31'd0, frame_done}, {31'd0, (k % 16) == 0});
      chk("idle_key", {16'd0, key_n}, 32'hFFFF);
      chk("idle_kc", {31'd0, key_change}, 32'd0);
    end

    // Hold "5": accepted on the third identical frame, one pulse only.
    kc0   = kc_cnt;
    press = 16'h0020;
    hold_frames("k5_wait", 2, 16'hFFFF);
    accept("k5_acc", 16'hFFDF);
    hold_frames("k5_hold", 2, 16'hFFDF);
    chk("k5_pulses", kc_cnt - kc0, 32'd1);

    // Release: back to idle after three clean frames.
    kc0   = kc_cnt;
    press = 16'h0000;
    hold_frames("rel_wait", 2, 16'hFFDF);
    accept("rel_acc", 16'hFFFF);
    hold_frames("rel_hold", 1, 16'hFFFF);
    chk("rel_pulses", kc_cnt - kc0, 32'd1);

    // Bounce: 2 held, 1 released, 3 held.
    press = 16'h0020;
    hold_frames("bn_a", 2, 16'hFFFF);
    press = 16'h0000;
    hold_frames("bn_b", 1, 16'hFFFF);
    press = 16'h0020;
    hold_frames("bn_c", 2, 16'hFFFF);
    accept("bn_acc", 16'hFFDF);

    // "D" and "*" together.
    press = 16'h8008;
    hold_frames("two_wait", 2, 16'hFFDF);
    accept("two_acc", 16'h7FF7);

    // Back to "5", then reset mid-sweep.
    press = 16'h0020;
    hold_frames("pre_wait", 2, 16'h7FF7);
    accept("pre_acc", 16'hFFDF);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_key", {16'd0, key_n}, 32'hFFFF);
    chk("arst_col", {28'd0, col_n}, 32'hE);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ec = 4'hF;
      ec[(k/4)%4] = 1'b0;
      chk("rs_col", {28'd0, col_n}, {28'd0, ec});
      chk("rs_fd", {31'd0, frame_done}, {31'd0, k == 16});
    end
    chk("rs_key1", {16'd0, key_n}, 32'hFFFF);
    hold_frames("rs_wait", 1, 16'hFFFF);
    accept("rs_acc", 16'hFFDF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
